fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the program counter, drives the word-aligned fetch address into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. Downstream it feeds the decode stage. It accepts stall and redirect (branch/jump) requests from the hazard and decode logic.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- IMEM_WORDS, 50: instruction-memory depth in words. Fetches at or beyond this depth are out of range.
- NOP, 32'h0000_0000: encoding injected as a bubble (sll $0,$0,0).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and IF/ID (load-use hazard).
- redirect  in  1  taken branch or jump resolved in ID.
- redirect_pc  in  32  target of redirect.
- imem_addr  out  32  byte address to the instruction memory, equal to pc.
- imem_instr  in  32  instruction word returned combinationally for imem_addr.
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc4  out  32  IF/ID PC+4.
- ifid_valid  out  1  IF/ID holds a real instruction; 0 means bubble.
- fetch_fault  out  1  sticky; set when an out-of-range address was fetched.
- fetch_count  out  32  number of instructions accepted into IF/ID.

## Operation
- Internal pc register; imem_addr = pc. pc[1:0] is always 2'b00.
- Out of range: pc[31:2] >= IMEM_WORDS. The captured instruction is replaced by NOP with valid = 0, fetch_fault is set, and the PC still advances.
- Per-edge priority (highest first):
  - Redirect: pc <= {redirect_pc[31:2], 2'b00}; IF/ID <= bubble (instr = NOP, pc4 = 0, valid = 0). Redirect overrides stall.
  - Stall: pc and IF/ID hold all their values, and fetch_count holds.
  - Normal: pc <= pc + 4; ifid_instr <= imem_instr; ifid_pc4 <= pc + 4; ifid_valid <= 1; fetch_count <= fetch_count + 1.
- Arithmetic:
  - All adds are 32-bit modulo. pc = 32'hFFFF_FFFC advances to 0, which is out of range only if IMEM_WORDS is 0.
  - fetch_count saturates at 32'hFFFF_FFFF.
  - fetch_count does not increment on an out-of-range fetch or on a redirect.
- fetch_fault clears only on reset.
- Misaligned redirect_pc: the low two bits are silently dropped; no fault is raised.

## Timing
- Reset (async assert, any time including mid-stall or mid-redirect):
  - pc = RESET_PC, ifid_instr = NOP, ifid_pc4 = 0, ifid_valid = 0, fetch_fault = 0, fetch_count = 0.
  - imem_addr = RESET_PC immediately.
- Deassertion is sampled at the next rising edge. The first edge after release captures the word at RESET_PC.
- Fetch latency: an instruction at address A appears on ifid_instr one edge after pc == A with no stall.
- Redirect:
  - The target is fetched in the cycle after the redirect edge.
  - Exactly one bubble appears in IF/ID: the wrong-path slot.
  - redirect and stall are sampled in the same cycle. A redirect held for N cycles re-applies the same target each cycle, giving N bubbles.
- Stall has zero-cycle effect: outputs are unchanged at the edge where stall = 1.
- No combinational path from stall or redirect to any output.

## Structure
- Shared package pipeline_pkg:
  - NOP_INSTR constant.
  - RESET_PC default.
  - Struct ifid_t {instr[31:0], pc4[31:0], valid}, which the decode stage also uses.
- One natural sub-module, pc_reg: the PC register with next-PC priority mux (redirect > stall > +4) and alignment masking.
- The IF/ID register, fault flag and counter live in fetch_stage.
- The instruction memory stays external and is connected via imem_addr/imem_instr.

## Test plan
- Reset then free-run with the memory holding 0x20080001, 0x20090002, 0x01095020 at words 0–2:
  - after three edges, ifid_instr sequence is 0x20080001, 0x20090002, 0x01095020;
  - ifid_pc4 is 4, 8, 12;
  - fetch_count = 3.
- Stall held two cycles while pc = 8: pc, ifid_instr (0x20090002) and fetch_count are unchanged for two edges; fetch resumes at 8.
- Redirect to 0x14 while pc = 0xC: next edge gives ifid_valid = 0, ifid_instr = 0, pc = 0x14; the following edge captures word 5.
- Redirect and stall in the same cycle to 0x17: pc = 0x14 and a bubble is inserted (redirect wins, alignment applied).
- Run pc to word 50 (IMEM_WORDS = 50): ifid_valid = 0, ifid_instr = NOP, fetch_fault = 1, pc advances to 0xCC, and fetch_count does not increment.
- Assert rst_n low mid-stall between clock edges: all outputs go to their reset values without waiting for a clock edge, and fetch_fault clears.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Types and constants shared by the pipeline stages.
// Holds the IF/ID record, the bubble encoding and a saturating counter helper.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/redirect control in, instruction memory port, IF/ID outputs.
// The master modport is the fetch stage; the slave modport is its surroundings.
interface fetch_stage_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    modport master (
        input  stall, redirect, redirect_pc, imem_instr,
        output imem_addr, ifid_instr, ifid_pc4, ifid_valid, fetch_fault, fetch_count
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_instr,
        input  imem_addr, ifid_instr, ifid_pc4, ifid_valid, fetch_fault, fetch_count
    );
endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter with next-PC selection: redirect over stall over sequential +4.
// Both the reset value and redirect targets are forced word-aligned.
module pc_reg
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_pc
);

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] w_target;

    assign w_target = i_redirect_pc & ALIGN_MASK;

    always_comb begin
        w_pc_next = r_pc + 32'd4;
        if (i_redirect) begin
            w_pc_next = w_target;
        end else if (i_stall) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC & ALIGN_MASK;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: drives the PC to the external instruction memory and captures
// the returned word into IF/ID, tracking out-of-range fetches and accepted instructions.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_WORDS = 50,
    parameter logic [31:0] NOP        = NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    localparam ifid_t IFID_BUBBLE = '{instr: NOP, pc4: 32'h0, valid: 1'b0};

    logic [31:0] w_pc;
    logic [31:0] w_pc4;
    logic        w_oor;

    ifid_t       r_ifid;
    ifid_t       w_ifid_next;
    logic        r_fault;
    logic        w_fault_next;
    logic [31:0] r_count;
    logic [31:0] w_count_next;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_stall       (bus.stall),
        .i_redirect    (bus.redirect),
        .i_redirect_pc (bus.redirect_pc),
        .o_pc          (w_pc)
    );

    assign w_pc4 = w_pc + 32'd4;
    assign w_oor = ({2'b00, w_pc[31:2]} >= IMEM_WORDS);

    // Redirect squashes the wrong-path slot; a stall freezes everything.
    always_comb begin
        w_ifid_next  = r_ifid;
        w_fault_next = r_fault;
        w_count_next = r_count;
        if (bus.redirect) begin
            w_ifid_next = IFID_BUBBLE;
        end else if (!bus.stall) begin
            if (w_oor) begin
                w_ifid_next  = '{instr: NOP, pc4: w_pc4, valid: 1'b0};
                w_fault_next = 1'b1;
            end else begin
                w_ifid_next  = '{instr: bus.imem_instr, pc4: w_pc4, valid: 1'b1};
                w_count_next = sat_inc(r_count);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifid  <= IFID_BUBBLE;
            r_fault <= 1'b0;
            r_count <= 32'h0;
        end else begin
            r_ifid  <= w_ifid_next;
            r_fault <= w_fault_next;
            r_count <= w_count_next;
        end
    end

    assign bus.imem_addr   = w_pc;
    assign bus.ifid_instr  = r_ifid.instr;
    assign bus.ifid_pc4    = r_ifid.pc4;
    assign bus.ifid_valid  = r_ifid.valid;
    assign bus.fetch_fault = r_fault;
    assign bus.fetch_count = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a cycle-level behavioural model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_fetch_stage;

    localparam int          WORDS  = 50;
    localparam logic [31:0] NOPV   = 32'h0000_0000;
    localparam logic [31:0] OOR_RD = 32'hBADC_0DE0;

    logic clk;
    logic rst_n;
    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (WORDS),
        .NOP        (NOPV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 0;

    logic [31:0] mem [0:63];

    function automatic logic [31:0] bench_mem(input logic [31:0] addr);
        logic [31:0] w;
        w = addr >> 2;
        if (w < 64) return mem[w[5:0]];
        return OOR_RD;
    endfunction

    assign bus.imem_instr = bench_mem(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: what IF/ID and the counters must hold after each edge.
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid, m_fault;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 0; m_instr = NOPV; m_pc4 = 0; m_valid = 0; m_fault = 0; m_count = 0;
        end else if (bus.redirect) begin
            m_pc = {bus.redirect_pc[31:2], 2'b00};
            m_instr = NOPV; m_pc4 = 0; m_valid = 0;
        end else if (!bus.stall) begin
            m_pc4 = m_pc + 4;
            if ((m_pc >> 2) >= WORDS) begin
                m_instr = NOPV; m_valid = 0; m_fault = 1;
            end else begin
                m_instr = bench_mem(m_pc); m_valid = 1;
                if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            end
            m_pc = m_pc + 4;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("model imem_addr",   bus.imem_addr,   m_pc);
            chk("model ifid_instr",  bus.ifid_instr,  m_instr);
            chk("model ifid_pc4",    bus.ifid_pc4,    m_pc4);
            chk("model ifid_valid",  {31'b0, bus.ifid_valid},  {31'b0, m_valid});
            chk("model fetch_fault", {31'b0, bus.fetch_fault}, {31'b0, m_fault});
            chk("model fetch_count", bus.fetch_count, m_count);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ifid(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                               input logic [31:0] pc4, input logic valid, input logic [31:0] cnt);
        chk({tag, " addr"},  bus.imem_addr, addr);
        chk({tag, " instr"}, bus.ifid_instr, instr);
        chk({tag, " pc4"},   bus.ifid_pc4, pc4);
        chk({tag, " valid"}, {31'b0, bus.ifid_valid}, {31'b0, valid});
        chk({tag, " count"}, bus.fetch_count, cnt);
    endtask

    task automatic expect_reset(input string tag);
        expect_ifid(tag, 32'h0, NOPV, 32'h0, 1'b0, 32'h0);
        chk({tag, " fault"}, {31'b0, bus.fetch_fault}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h2400_0000 + i;
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0002;
        mem[2] = 32'h0109_5020;
        bus.stall = 0; bus.redirect = 0; bus.redirect_pc = 0;
        rst_n = 0;
        #2;
        expect_reset("reset");
        checking = 1;
        @(posedge clk); #1;
        rst_n = 1;

        tick(1); expect_ifid("fetch0", 32'h4, 32'h2008_0001, 32'h4, 1'b1, 1);
        tick(1); expect_ifid("fetch1", 32'h8, 32'h2009_0002, 32'h8, 1'b1, 2);

        bus.stall = 1;
        tick(1); expect_ifid("stall1", 32'h8, 32'h2009_0002, 32'h8, 1'b1, 2);
        tick(1); expect_ifid("stall2", 32'h8, 32'h2009_0002, 32'h8, 1'b1, 2);
        bus.stall = 0;
        tick(1); expect_ifid("resume", 32'hC, 32'h0109_5020, 32'hC, 1'b1, 3);

        bus.redirect = 1; bus.redirect_pc = 32'h14;
        tick(1); expect_ifid("redir bubble", 32'h14, NOPV, 32'h0, 1'b0, 3);
        bus.redirect = 0;
        tick(1); expect_ifid("redir target", 32'h18, 32'h2400_0005, 32'h18, 1'b1, 4);

        bus.redirect = 1; bus.stall = 1; bus.redirect_pc = 32'h17;
        tick(1); expect_ifid("redir+stall", 32'h14, NOPV, 32'h0, 1'b0, 4);
        bus.redirect = 0; bus.stall = 0;
        tick(1); expect_ifid("after r+s", 32'h18, 32'h2400_0005, 32'h18, 1'b1, 5);

        bus.redirect = 1; bus.redirect_pc = 32'hB;
        tick(1); expect_ifid("held redir1", 32'h8, NOPV, 32'h0, 1'b0, 5);
        tick(1); expect_ifid("held redir2", 32'h8, NOPV, 32'h0, 1'b0, 5);
        bus.redirect = 0;
        tick(1); expect_ifid("after held", 32'hC, 32'h0109_5020, 32'hC, 1'b1, 6);

        bus.redirect = 1; bus.redirect_pc = 32'hC0;
        tick(1); bus.redirect = 0;
        tick(1); expect_ifid("word48", 32'hC4, 32'h2400_0030, 32'hC4, 1'b1, 7);
        tick(1); expect_ifid("word49", 32'hC8, 32'h2400_0031, 32'hC8, 1'b1, 8);
        chk("fault before oor", {31'b0, bus.fetch_fault}, 32'h0);
        tick(1); expect_ifid("word50 oor", 32'hCC, NOPV, 32'hCC, 1'b0, 8);
        chk("fault at oor", {31'b0, bus.fetch_fault}, 32'h1);
        tick(1); expect_ifid("word51 oor", 32'hD0, NOPV, 32'hD0, 1'b0, 8);
        chk("fault sticky", {31'b0, bus.fetch_fault}, 32'h1);

        bus.stall = 1;
        tick(1);
        #3;
        rst_n = 0;
        #1;
        expect_reset("async reset");
        @(posedge clk); #1;
        rst_n = 1; bus.stall = 0;

        bus.redirect = 1; bus.redirect_pc = 32'hFFFF_FFFE;
        tick(1); expect_ifid("wrap redir", 32'hFFFF_FFFC, NOPV, 32'h0, 1'b0, 0);
        bus.redirect = 0;
        tick(1); expect_ifid("wrap oor", 32'h0, NOPV, 32'h0, 1'b0, 0);
        chk("wrap fault", {31'b0, bus.fetch_fault}, 32'h1);
        tick(1); expect_ifid("wrap fetch0", 32'h4, 32'h2008_0001, 32'h4, 1'b1, 1);

        tick(2);
        checking = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
